// File: rtl/core_types_pkg.sv
// Shared core types and sizing for the rename stage.
// The free list pointer carries one extra msb so that full and empty can be told apart.
package core_types_pkg;

  localparam int NUM_PHYS_REGS          = 64;
  localparam int PHYS_REG_WIDTH         = 6;
  localparam int NUM_ARCH_REGS          = 32;
  localparam int FREE_LIST_DEPTH        = 64;
  localparam int LOG_FREE_LIST_DEPTH    = 6;
  localparam int CHECKPOINT_COLUMNS     = 4;
  localparam int LOG_CHECKPOINT_COLUMNS = 2;

  typedef logic [PHYS_REG_WIDTH-1:0]         phys_reg_tag_t;
  typedef logic [LOG_CHECKPOINT_COLUMNS-1:0] checkpoint_column_t;
  typedef logic [LOG_FREE_LIST_DEPTH:0]      free_list_ptr_t;

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags with checkpointed head pointers
// so a mispredict can hand back every speculatively allocated tag in one cycle.
module phys_reg_free_list
  import core_types_pkg::*;
(
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         dequeue_valid,
  output logic                         dequeue_ready,
  output phys_reg_tag_t                dequeue_phys_reg_tag,
  input  logic                         enqueue_valid,
  input  phys_reg_tag_t                enqueue_phys_reg_tag,
  input  logic                         save_checkpoint_valid,
  input  checkpoint_column_t           save_checkpoint_column,
  input  logic                         restore_checkpoint_valid,
  input  checkpoint_column_t           restore_checkpoint_column,
  output logic [LOG_FREE_LIST_DEPTH:0] free_count,
  output logic                         overflow_error
);

  phys_reg_tag_t  buffer [FREE_LIST_DEPTH];
  free_list_ptr_t head;
  free_list_ptr_t tail;
  free_list_ptr_t checkpoint_head [CHECKPOINT_COLUMNS];

  logic empty;
  logic full;
  logic dequeue_fire;
  logic enqueue_fire;

  assign empty = (head == tail);
  assign full  = (head[LOG_FREE_LIST_DEPTH-1:0] == tail[LOG_FREE_LIST_DEPTH-1:0]) &&
                 (head[LOG_FREE_LIST_DEPTH] != tail[LOG_FREE_LIST_DEPTH]);

  // A restore owns the head this cycle, so a concurrent allocation is refused.
  assign dequeue_fire = dequeue_valid && !empty && !restore_checkpoint_valid;
  assign enqueue_fire = enqueue_valid && !full;

  assign dequeue_ready        = !empty;
  assign dequeue_phys_reg_tag = buffer[head[LOG_FREE_LIST_DEPTH-1:0]];
  assign free_count           = tail - head;

  // Tags above the architectural set start out free; the rest of the ring is blank.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
        buffer[i] <= (i < NUM_ARCH_REGS) ? phys_reg_tag_t'(i + NUM_ARCH_REGS) : '0;
      end
    end else if (enqueue_fire) begin
      buffer[tail[LOG_FREE_LIST_DEPTH-1:0]] <= enqueue_phys_reg_tag;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head <= '0;
    end else if (restore_checkpoint_valid) begin
      head <= checkpoint_head[restore_checkpoint_column];
    end else if (dequeue_fire) begin
      head <= head + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tail           <= free_list_ptr_t'(NUM_ARCH_REGS);
      overflow_error <= 1'b0;
    end else if (enqueue_fire) begin
      tail <= tail + 1'b1;
    end else if (enqueue_valid) begin
      overflow_error <= 1'b1;
    end
  end

  // Saving captures the head before this cycle's dequeue or restore lands.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
        checkpoint_head[c] <= '0;
      end
    end else if (save_checkpoint_valid) begin
      checkpoint_head[save_checkpoint_column] <= head;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboarded bench for phys_reg_free_list: stimulus queues expected tags,
// a negedge monitor pops them whenever the DUT accepts a dequeue.
module tb_phys_reg_free_list;
  import core_types_pkg::*;

  logic               CLK;
  logic               RST;
  logic               dequeue_valid;
  logic               dequeue_ready;
  phys_reg_tag_t      dequeue_phys_reg_tag;
  logic               enqueue_valid;
  phys_reg_tag_t      enqueue_phys_reg_tag;
  logic               save_checkpoint_valid;
  checkpoint_column_t save_checkpoint_column;
  logic               restore_checkpoint_valid;
  checkpoint_column_t restore_checkpoint_column;
  logic [6:0]         free_count;
  logic               overflow_error;

  int check_count = 0;
  int error_count = 0;
  phys_reg_tag_t exp_q [$];
  phys_reg_tag_t ref_q [$];

  phys_reg_free_list dut (
    .CLK                      (CLK),
    .RST                      (RST),
    .dequeue_valid            (dequeue_valid),
    .dequeue_ready            (dequeue_ready),
    .dequeue_phys_reg_tag     (dequeue_phys_reg_tag),
    .enqueue_valid            (enqueue_valid),
    .enqueue_phys_reg_tag     (enqueue_phys_reg_tag),
    .save_checkpoint_valid    (save_checkpoint_valid),
    .save_checkpoint_column   (save_checkpoint_column),
    .restore_checkpoint_valid (restore_checkpoint_valid),
    .restore_checkpoint_column(restore_checkpoint_column),
    .free_count               (free_count),
    .overflow_error           (overflow_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Any accepted handshake must match the oldest tag the stimulus predicted.
  always @(negedge CLK) begin
    if (!RST && dequeue_valid && dequeue_ready && !restore_checkpoint_valid) begin
      check_count++;
      if (exp_q.size() == 0) begin
        error_count++;
        $display("[TB] FAIL unexpected_dequeue actual=%0d required=none", dequeue_phys_reg_tag);
      end else begin
        phys_reg_tag_t exp_tag;
        exp_tag = exp_q.pop_front();
        if (dequeue_phys_reg_tag !== exp_tag) begin
          error_count++;
          $display("[TB] FAIL dequeue_tag actual=%0d required=%0d", dequeue_phys_reg_tag, exp_tag);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic deq, input logic enq, input phys_reg_tag_t enq_tag,
                               input logic save, input checkpoint_column_t save_col,
                               input logic restore, input checkpoint_column_t restore_col);
    dequeue_valid             = deq;
    enqueue_valid             = enq;
    enqueue_phys_reg_tag      = enq_tag;
    save_checkpoint_valid     = save;
    save_checkpoint_column    = save_col;
    restore_checkpoint_valid  = restore;
    restore_checkpoint_column = restore_col;
    @(posedge CLK);
    #1;
    dequeue_valid            = 1'b0;
    enqueue_valid            = 1'b0;
    save_checkpoint_valid    = 1'b0;
    restore_checkpoint_valid = 1'b0;
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_count"}, free_count, 7'd32);
    checkOutput({name, "_ready"}, {6'd0, dequeue_ready}, 7'd1);
    checkOutput({name, "_tag"}, {1'b0, dequeue_phys_reg_tag}, 7'd32);
    checkOutput({name, "_overflow"}, {6'd0, overflow_error}, 7'd0);
  endtask

  // Reset is raised between edges so the asynchronous path is what gets observed.
  task automatic pulseReset(input string name);
    RST = 1'b1;
    #1;
    checkResetState(name);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    dequeue_valid = 0; enqueue_valid = 0; enqueue_phys_reg_tag = '0;
    save_checkpoint_valid = 0; save_checkpoint_column = '0;
    restore_checkpoint_valid = 0; restore_checkpoint_column = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    checkResetState("reset");

    // Drain the initial free tags.
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(phys_reg_tag_t'(32 + i));
      applyStimulus(1, 0, '0, 0, '0, 0, '0);
    end
    checkOutput("drained_count", free_count, 7'd0);
    checkOutput("drained_ready", {6'd0, dequeue_ready}, 7'd0);

    // Enqueue into an empty list while requesting: no bypass.
    applyStimulus(1, 1, 6'd7, 0, '0, 0, '0);
    checkOutput("refill_ready", {6'd0, dequeue_ready}, 7'd1);
    checkOutput("refill_tag", {1'b0, dequeue_phys_reg_tag}, 7'd7);
    checkOutput("refill_count", free_count, 7'd1);
    exp_q.push_back(6'd7);
    applyStimulus(1, 0, '0, 0, '0, 0, '0);
    checkOutput("refill_drained", free_count, 7'd0);

    pulseReset("async_reset1");

    // Checkpoint save, speculative allocation, then rewind.
    applyStimulus(0, 0, '0, 1, 2'd1, 0, '0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(phys_reg_tag_t'(32 + i));
      applyStimulus(1, 0, '0, 0, '0, 0, '0);
    end
    checkOutput("spec_count", free_count, 7'd29);
    applyStimulus(0, 0, '0, 0, '0, 1, 2'd1);
    checkOutput("restore_tag", {1'b0, dequeue_phys_reg_tag}, 7'd32);
    checkOutput("restore_count", free_count, 7'd32);

    applyStimulus(1, 1, 6'd5, 0, '0, 1, 2'd1);
    checkOutput("restore_enq_count", free_count, 7'd33);
    checkOutput("restore_enq_tag", {1'b0, dequeue_phys_reg_tag}, 7'd32);

    // Save and restore of the same column: restore sees the old value.
    exp_q.push_back(6'd32);
    exp_q.push_back(6'd33);
    applyStimulus(1, 0, '0, 0, '0, 0, '0);
    applyStimulus(1, 0, '0, 0, '0, 0, '0);
    applyStimulus(0, 0, '0, 1, 2'd1, 1, 2'd1);
    checkOutput("save_restore_count", free_count, 7'd33);
    checkOutput("save_restore_tag", {1'b0, dequeue_phys_reg_tag}, 7'd32);
    applyStimulus(0, 0, '0, 0, '0, 1, 2'd1);
    checkOutput("second_restore_count", free_count, 7'd31);
    checkOutput("second_restore_tag", {1'b0, dequeue_phys_reg_tag}, 7'd34);

    pulseReset("async_reset2");

    // Fill to full, overflow, then drain across the wrap.
    for (int i = 0; i < 32; i++) applyStimulus(0, 1, phys_reg_tag_t'(i), 0, '0, 0, '0);
    checkOutput("full_count", free_count, 7'd64);
    checkOutput("full_overflow_clear", {6'd0, overflow_error}, 7'd0);
    applyStimulus(0, 1, 6'd9, 0, '0, 0, '0);
    checkOutput("overflow_count", free_count, 7'd64);
    checkOutput("overflow_set", {6'd0, overflow_error}, 7'd1);
    exp_q.push_back(6'd32);
    applyStimulus(1, 0, '0, 0, '0, 0, '0);
    checkOutput("overflow_sticky", {6'd0, overflow_error}, 7'd1);
    applyStimulus(0, 1, 6'd9, 0, '0, 0, '0);
    checkOutput("wrap_full_count", free_count, 7'd64);
    for (int i = 33; i < 64; i++) exp_q.push_back(phys_reg_tag_t'(i));
    for (int i = 0; i < 32; i++) exp_q.push_back(phys_reg_tag_t'(i));
    exp_q.push_back(6'd9);
    for (int i = 0; i < 64; i++) applyStimulus(1, 0, '0, 0, '0, 0, '0);
    checkOutput("wrap_drained_count", free_count, 7'd0);
    checkOutput("wrap_drained_ready", {6'd0, dequeue_ready}, 7'd0);

    pulseReset("async_reset3");

    // Random interleaving against a reference FIFO, with a reset mid-stream.
    for (int i = 32; i < 64; i++) ref_q.push_back(phys_reg_tag_t'(i));
    for (int cyc = 0; cyc < 200; cyc++) begin
      logic deq, enq;
      phys_reg_tag_t tag;
      if (cyc == 120) begin
        pulseReset("mid_stream_reset");
        ref_q.delete();
        for (int i = 32; i < 64; i++) ref_q.push_back(phys_reg_tag_t'(i));
      end
      deq = 1'($urandom_range(0, 1));
      enq = 1'($urandom_range(0, 1)) && (ref_q.size() < 64);
      tag = phys_reg_tag_t'($urandom_range(0, 63));
      if (deq && ref_q.size() > 0) exp_q.push_back(ref_q.pop_front());
      if (enq) ref_q.push_back(tag);
      applyStimulus(deq, enq, tag, 0, '0, 0, '0);
      checkOutput("random_count", free_count, 7'(ref_q.size()));
    end

    checkOutput("scoreboard_empty", 7'(exp_q.size()), 7'd0);
    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
Circular FIFO of free physical register tags that feeds rename/dispatch. Supplies one free phys reg tag per cycle for a renamed destination register. Accepts one freed tag per cycle from ROB commit or revert. Keeps CHECKPOINT_COLUMNS saved head pointers so branch mispredict recovery can return speculatively allocated tags in one cycle.

Parameters:
NUM_PHYS_REGS, 64, total physical registers; tag width PHYS_REG_WIDTH = 6
NUM_ARCH_REGS, 32, arch regs mapped 1:1 to phys regs 0..31 at reset
FREE_LIST_DEPTH, 64, FIFO entries; LOG_FREE_LIST_DEPTH = 6
CHECKPOINT_COLUMNS, 4, saved head pointers; LOG_CHECKPOINT_COLUMNS = 2

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
dequeue_valid  in  1  rename requests a free tag
dequeue_ready  out  1  free list non-empty
dequeue_phys_reg_tag  out  6  tag at head; consumed when valid&ready
enqueue_valid  in  1  tag being freed
enqueue_phys_reg_tag  in  6  freed tag
save_checkpoint_valid  in  1  capture head into column
save_checkpoint_column  in  2  column to write
restore_checkpoint_valid  in  1  rewind head from column
restore_checkpoint_column  in  2  column to read
free_count  out  7  number of free tags, 0..64
overflow_error  out  1  sticky; enqueue attempted while full

Behaviour:
Clock and reset:
- One clock domain, CLK.
- Reset is asynchronous, active-high, on port RST.
- Asserting RST at any time, including mid-operation, forces the reset state immediately.

State:
- buffer[64] of phys_reg_tag_t.
- head and tail pointers, 7 bits each (extra msb for wrap).
- checkpoint_head[4], 7 bits each.
- overflow_error flop.

Reset state:
- buffer[i] = i+32 for i in 0..31; buffer[32..63] = 0.
- head = 0, tail = 32, all checkpoint_head = 0, overflow_error = 0.
- Resulting outputs: dequeue_ready = 1, dequeue_phys_reg_tag = 32, free_count = 32.

Outputs:
- Combinational from registered state only; no enqueue-to-dequeue bypass.
- empty = (head == tail); full = low 6 bits equal and msbs differ.
- free_count = tail - head (7-bit modulo).
- dequeue_ready = !empty.
- dequeue_phys_reg_tag = buffer[head[5:0]].

Dequeue:
- On dequeue_valid & dequeue_ready, head <= head+1.
- dequeue_valid while empty is ignored; no state change.

Enqueue:
- On enqueue_valid & !full: buffer[tail[5:0]] <= tag, tail <= tail+1.
- On enqueue_valid & full: tag dropped, overflow_error <= 1 (sticky until reset).

Save checkpoint:
- save_checkpoint_valid: checkpoint_head[save_checkpoint_column] <= head (pre-dequeue value of this cycle).

Restore checkpoint:
- restore_checkpoint_valid: head <= checkpoint_head[restore_checkpoint_column].
- Any dequeue in the same cycle is not accepted; the tag is not consumed.
- Enqueue in the same cycle is still processed; tail is independent of restore.

Simultaneous events:
- Enqueue and dequeue in the same cycle are both processed; count is unchanged.
- Save and restore in the same cycle: restore reads the old column contents; save writes the current head (same column included).

Wrap-around:
- Pointers increment modulo 128. Index uses bits [5:0]; msb disambiguates full from empty.

Latency:
- An enqueued tag is dequeueable the cycle after the enqueue.
- A restored head takes effect the next cycle.

Decomposition:
Add to core_types_pkg:
- typedef free_list_ptr_t = logic [LOG_FREE_LIST_DEPTH:0].

Reuse from core_types_pkg:
- phys_reg_tag_t, checkpoint_column_t, FREE_LIST_DEPTH, CHECKPOINT_COLUMNS, NUM_ARCH_REGS.

Sub-modules:
- No sub-module required.
- The checkpoint pointer array may be split into free_list_checkpoint_table if reused by the map table; otherwise keep it inline.

Test Plan:
- Reset, then 32 back-to-back dequeues -> tags 32..63 in order; after the 32nd, dequeue_ready = 0 and free_count = 0.
- List empty; enqueue tag 7 with dequeue_valid = 1 in the same cycle -> no dequeue that cycle; next cycle dequeue_ready = 1, tag = 7, free_count = 1.
- Save column 1 at head 0; dequeue 3 (32, 33, 34); restore column 1 -> next cycle tag = 32, free_count = 32.
- Restore column 1 with enqueue tag 5 and dequeue_valid in the same cycle -> head = saved value, tail +1, no dequeue accepted, free_count = 33.
- From reset, enqueue tags 0..31 -> free_count = 64; one more enqueue -> dropped, overflow_error = 1, stays 1 until RST.
- 200 cycles of random interleaved enqueue/dequeue crossing the wrap -> dequeued order matches a reference FIFO; free_count tracks exactly; RST asserted mid-stream -> immediate return to reset state.
